// File: rtl/lc3_mem_xfer_unit.sv
// MAR/MDR memory transfer unit for the multicycle LC-3: read, write, LDI and STI
// over a req/ack memory port. Define MEMX_TIMEOUT_EN to add an access timeout (rsp_err).
module lc3_mem_xfer_unit #(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mar,
  output logic [DATA_W-1:0] mdr
);

  typedef enum logic [1:0] {IDLE, PTR, ACC, RESP} state_t;

  state_t     state;
  logic [1:0] op;
  logic       timed_out;

  if (ADDR_W > DATA_W || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("lc3_mem_xfer_unit: ADDR_W must be <= DATA_W and TIMEOUT_CYCLES >= 2");
  end

  assign mem_addr  = mar;
  assign mem_wdata = mdr;
  assign rsp_data  = mdr;

`ifdef MEMX_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign timed_out = mem_req && !mem_ack && (cnt == CNT_LAST);

  // Counter restarts on every ack so PTR and ACC each get a full timeout window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (state == IDLE || mem_ack) cnt <= '0;
      else if (mem_req)             cnt <= cnt + CNT_W'(1);
      if (timed_out)                     rsp_err <= 1'b1;
      else if (state == RESP && rsp_ready) rsp_err <= 1'b0;
    end
  end
`else
  assign timed_out = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op        <= 2'b00;
      mar       <= '0;
      mdr       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            mar       <= req_addr;
            op        <= req_op;
            if (req_op[0]) mdr <= req_wdata;
            req_ready <= 1'b0;
            mem_req   <= 1'b1;
            if (req_op[1]) begin
              state  <= PTR;
              mem_we <= 1'b0;
            end else begin
              state  <= ACC;
              mem_we <= req_op[0];
            end
          end
        end
        PTR: begin
          if (mem_ack) begin
            mar    <= mem_rdata[ADDR_W-1:0];
            mem_we <= op[0];
            state  <= ACC;
          end else if (timed_out) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mdr       <= '0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        ACC: begin
          if (mem_ack || timed_out) begin
            if (timed_out)   mdr <= '0;
            else if (!op[0]) mdr <= mem_rdata;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_mem_xfer_unit.sv
// Directed bench for lc3_mem_xfer_unit: vector table plus backpressure, reset and
// (with MEMX_TIMEOUT_EN) timeout sequences against a behavioural memory.
module tb_lc3_mem_xfer_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_data;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] mar, mdr;

  lc3_mem_xfer_unit #(.DATA_W(16), .ADDR_W(16), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mar(mar), .mdr(mdr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural memory: acks after wait_n stall cycles, or never when ack_never is set.
  logic [15:0] mem [logic [15:0]];
  int          wait_n = 0;
  bit          ack_never = 1'b0;
  int          wcnt = 0;
  int          nacc = 0, nwr = 0;
  bit          prev_hold = 1'b0;
  logic [15:0] prev_addr, prev_wdata;
  logic        prev_we;

  function automatic logic [15:0] rd(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      mem_ack   = 1'b0;
      mem_rdata = 16'hDEAD;
      wcnt      = 0;
      prev_hold = 1'b0;
    end else begin
      if (!mem_req && mem_we) check("we_without_req", 32'(mem_we), 32'd0);
      if (prev_hold && !(rsp_valid && rsp_err)) begin
        check("req_held", 32'(mem_req), 32'd1);
        check("addr_stable", 32'(mem_addr), 32'(prev_addr));
        check("we_stable", 32'(mem_we), 32'(prev_we));
        check("wdata_stable", 32'(mem_wdata), 32'(prev_wdata));
      end
      if (mem_req && !ack_never && wcnt == wait_n) begin
        mem_ack   = 1'b1;
        mem_rdata = rd(mem_addr);
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
          nwr++;
        end
        nacc++;
        wcnt = 0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 16'hDEAD;
        if (mem_req) wcnt++;
      end
      prev_hold  = mem_req && !mem_ack;
      prev_addr  = mem_addr;
      prev_we    = mem_we;
      prev_wdata = mem_wdata;
    end
  end

  task automatic start_req(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wdata);
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    nacc      = 0;
    nwr       = 0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
    end while (!rsp_valid && lat < 60);
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    check("req_ready_back", 32'(req_ready), 32'd1);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          wait_n;
    logic [15:0] exp_data;
    logic [15:0] exp_mar;
    int          exp_lat;
    int          exp_acc;
    int          exp_wr;
  } vec_t;

  vec_t vecs[7];
  int   lat;

  initial begin
    vecs[0] = '{2'b00, 16'h3000, 16'h0000, 0, 16'hBEEF, 16'h3000, 2, 1, 0};
    vecs[1] = '{2'b01, 16'h4000, 16'h1234, 3, 16'h1234, 16'h4000, 5, 1, 1};
    vecs[2] = '{2'b10, 16'h3001, 16'h0000, 0, 16'h00AA, 16'h5000, 3, 2, 0};
    vecs[3] = '{2'b11, 16'h3002, 16'hCAFE, 0, 16'hCAFE, 16'h6000, 3, 2, 1};
    vecs[4] = '{2'b00, 16'hFFFF, 16'h0000, 1, 16'h1357, 16'hFFFF, 3, 1, 0};
    vecs[5] = '{2'b10, 16'h3001, 16'h0000, 2, 16'h00AA, 16'h5000, 7, 2, 0};
    vecs[6] = '{2'b00, 16'h4000, 16'h0000, 0, 16'h1234, 16'h4000, 2, 1, 0};

    mem[16'h3000] = 16'hBEEF;
    mem[16'h3001] = 16'h5000;
    mem[16'h5000] = 16'h00AA;
    mem[16'h3002] = 16'h6000;
    mem[16'h3003] = 16'h6100;
    mem[16'hFFFF] = 16'h1357;

    reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; mem_ack = 1'b0; mem_rdata = 16'hDEAD;
    repeat (2) @(negedge clk);
    check("rst_mar", 32'(mar), 32'd0);
    check("rst_mdr", 32'(mdr), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);

    foreach (vecs[i]) begin
      wait_n = vecs[i].wait_n;
      start_req(vecs[i].op, vecs[i].addr, vecs[i].wdata);
      wait_rsp(lat);
      check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_data", i), 32'(rsp_data), 32'(vecs[i].exp_data));
      check($sformatf("v%0d_err", i), 32'(rsp_err), 32'd0);
      check($sformatf("v%0d_mar", i), 32'(mar), 32'(vecs[i].exp_mar));
      check($sformatf("v%0d_nacc", i), 32'(nacc), 32'(vecs[i].exp_acc));
      check($sformatf("v%0d_nwr", i), 32'(nwr), 32'(vecs[i].exp_wr));
      if (vecs[i].exp_wr != 0)
        check($sformatf("v%0d_memwr", i), 32'(rd(vecs[i].exp_mar)), 32'(vecs[i].wdata));
      finish_rsp();
    end

    // STI with response backpressure and a competing request during the stall.
    wait_n = 0;
    start_req(2'b11, 16'h3003, 16'hF00D);
    wait_rsp(lat);
    check("bp_lat", 32'(lat), 32'd3);
    check("bp_nacc", 32'(nacc), 32'd2);
    check("bp_nwr", 32'(nwr), 32'd1);
    check("bp_memwr", 32'(rd(16'h6100)), 32'h0000F00D);
    req_valid = 1'b1; req_op = 2'b00; req_addr = 16'h3000; req_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid_hold", 32'(rsp_valid), 32'd1);
      check("bp_data_hold", 32'(rsp_data), 32'h0000F00D);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_released", 32'(rsp_valid), 32'd0);
    check("bp_not_accepted", 32'(mem_req), 32'd0);
    check("bp_ready_after", 32'(req_ready), 32'd1);
    nacc = 0; nwr = 0;
    wait_rsp(lat);
    check("bp_next_lat", 32'(lat), 32'd2);
    check("bp_next_data", 32'(rsp_data), 32'h0000BEEF);
    finish_rsp();

    // Reset while an access is stalled in ACC.
    ack_never = 1'b1;
    start_req(2'b01, 16'h4400, 16'h7777);
    @(negedge clk);
    req_valid = 1'b0;
    check("rr_req_up", 32'(mem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rr_mem_req", 32'(mem_req), 32'd0);
    check("rr_mem_we", 32'(mem_we), 32'd0);
    check("rr_mar", 32'(mar), 32'd0);
    check("rr_mdr", 32'(mdr), 32'd0);
    check("rr_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ack_never = 1'b0;
    @(posedge clk); #1;
    check("rr_req_ready", 32'(req_ready), 32'd1);
    check("rr_idle_req", 32'(mem_req), 32'd0);
    start_req(2'b10, 16'h3001, 16'h0000);
    wait_rsp(lat);
    check("rr_after_lat", 32'(lat), 32'd3);
    check("rr_after_data", 32'(rsp_data), 32'h000000AA);
    finish_rsp();

`ifdef MEMX_TIMEOUT_EN
    begin
      int req_cycles = 0;
      ack_never = 1'b1;
      start_req(2'b00, 16'h7000, 16'h0000);
      lat = 0;
      do begin
        @(negedge clk);
        req_valid = 1'b0;
        if (mem_req) req_cycles++;
        lat++;
      end while (!rsp_valid && lat < 60);
      check("to_req_cycles", 32'(req_cycles), 32'd8);
      check("to_lat", 32'(lat), 32'd9);
      check("to_err", 32'(rsp_err), 32'd1);
      check("to_data", 32'(rsp_data), 32'd0);
      check("to_mem_req", 32'(mem_req), 32'd0);
      finish_rsp();
      check("to_err_clear", 32'(rsp_err), 32'd0);
      ack_never = 1'b0;
      start_req(2'b00, 16'h3000, 16'h0000);
      wait_rsp(lat);
      check("to_next_lat", 32'(lat), 32'd2);
      check("to_next_data", 32'(rsp_data), 32'h0000BEEF);
      check("to_next_err", 32'(rsp_err), 32'd0);
      finish_rsp();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
